// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Brief    : Program counter with increment, relative branch, absolute load,
//             stall, and a circular call/return address stack with sticky
//             overflow/underflow flags.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int unsigned           WIDTH     = 16,
    parameter int unsigned           INC       = 1,
    parameter logic [WIDTH-1:0]      RESET_VEC = '0,
    parameter int unsigned           RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         pc_load,
    input  logic [WIDTH-1:0]             load_data,
    input  logic                         br_take,
    input  logic [WIDTH-1:0]             br_offset,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         err_clr,
    output logic [WIDTH-1:0]             pc_out,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_full,
    output logic                         ras_empty,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam int unsigned          PTR_W     = $clog2(RAS_DEPTH);
    localparam int unsigned          CNT_W     = PTR_W + 1;
    localparam logic [WIDTH-1:0]     INC_VEC   = WIDTH'(INC);
    localparam logic [CNT_W-1:0]     DEPTH_CNT = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]     PTR_ONE   = PTR_W'(1);

    // Return-address storage; wr_ptr names the slot the next push lands in,
    // so the top of stack is always wr_ptr-1 and a push while full naturally
    // overwrites the oldest entry.
    logic [WIDTH-1:0]   ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   top_ptr;

    logic [WIDTH-1:0]   pc_inc;
    logic [WIDTH-1:0]   pc_branch;
    logic [WIDTH-1:0]   top_data;

    logic [WIDTH-1:0]   pc_next;
    logic [PTR_W-1:0]   ptr_next;
    logic [CNT_W-1:0]   count_next;
    logic               ovf_next;
    logic               unf_next;
    logic               push_en;

    assign top_ptr   = wr_ptr - PTR_ONE;
    assign top_data  = ras_mem[top_ptr];
    assign pc_inc    = pc_out + INC_VEC;
    assign pc_branch = pc_out + br_offset;

    assign ras_full  = (ras_count == DEPTH_CNT);
    assign ras_empty = (ras_count == '0);

    // Command arbitration: ret > call > pc_load > br_take > increment.
    always_comb begin
        pc_next    = pc_out;
        ptr_next   = wr_ptr;
        count_next = ras_count;
        ovf_next   = ras_ovf;
        unf_next   = ras_unf;
        push_en    = 1'b0;

        if (!stall) begin
            pc_next = pc_inc;

            // A clear is overridden below by any error raised in the same cycle.
            if (err_clr) begin
                ovf_next = 1'b0;
                unf_next = 1'b0;
            end

            if (ret) begin
                if (!ras_empty) begin
                    pc_next    = top_data;
                    ptr_next   = top_ptr;
                    count_next = ras_count - CNT_ONE;
                end else begin
                    unf_next   = 1'b1;
                end
            end else if (call) begin
                push_en  = 1'b1;
                pc_next  = load_data;
                ptr_next = wr_ptr + PTR_ONE;
                if (ras_full) begin
                    ovf_next = 1'b1;
                end else begin
                    count_next = ras_count + CNT_ONE;
                end
            end else if (pc_load) begin
                pc_next = load_data;
            end else if (br_take) begin
                pc_next = pc_branch;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out    <= RESET_VEC;
            wr_ptr    <= '0;
            ras_count <= '0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
        end else begin
            pc_out    <= pc_next;
            wr_ptr    <= ptr_next;
            ras_count <= count_next;
            ras_ovf   <= ovf_next;
            ras_unf   <= unf_next;
        end
    end

    // Stack contents carry no reset; validity is tracked solely by ras_count.
    always_ff @(posedge clk) begin
        if (push_en) begin
            ras_mem[wr_ptr] <= pc_inc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_unit
//  Brief    : Directed scoreboard bench for pc_unit (16-bit, INC=1, depth 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_STALL = 6'b100000;
    localparam logic [5:0] C_LOAD  = 6'b010000;
    localparam logic [5:0] C_BR    = 6'b001000;
    localparam logic [5:0] C_CALL  = 6'b000100;
    localparam logic [5:0] C_RET   = 6'b000010;
    localparam logic [5:0] C_CLR   = 6'b000001;

    typedef struct {
        logic [15:0] pc;
        int          cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, pc_load, br_take, call, ret, err_clr;
    logic [15:0] load_data, br_offset;
    logic [15:0] pc_out;
    logic [2:0]  ras_count;
    logic        ras_full, ras_empty, ras_ovf, ras_unf;

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];

    pc_unit #(
        .WIDTH(16), .INC(1), .RESET_VEC(16'h0000), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_load(pc_load),
        .load_data(load_data), .br_take(br_take), .br_offset(br_offset),
        .call(call), .ret(ret), .err_clr(err_clr), .pc_out(pc_out),
        .ras_count(ras_count), .ras_full(ras_full), .ras_empty(ras_empty),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag, input exp_t e);
        chk({tag, ".pc"},    pc_out,           e.pc);
        chk({tag, ".cnt"},   16'(ras_count),   16'(e.cnt));
        chk({tag, ".full"},  16'(ras_full),    16'(e.cnt == 4));
        chk({tag, ".empty"}, 16'(ras_empty),   16'(e.cnt == 0));
        chk({tag, ".ovf"},   16'(ras_ovf),     16'(e.ovf));
        chk({tag, ".unf"},   16'(ras_unf),     16'(e.unf));
    endtask

    // Drive one command ahead of the next rising edge and queue its outcome.
    task automatic step(input logic [5:0] cmd, input logic [15:0] ld, input logic [15:0] off,
                        input logic [15:0] e_pc, input int e_cnt, input logic e_ovf, input logic e_unf);
        exp_t e;
        @(negedge clk);
        {stall, pc_load, br_take, call, ret, err_clr} = cmd;
        load_data = ld;
        br_offset = off;
        e.pc = e_pc; e.cnt = e_cnt; e.ovf = e_ovf; e.unf = e_unf;
        sb_q.push_back(e);
    endtask

    // Monitor: each edge that has a queued expectation is checked 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk_state("step", e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t r;
        r.pc = 16'h0000; r.cnt = 0; r.ovf = 1'b0; r.unf = 1'b0;
        {stall, pc_load, br_take, call, ret, err_clr} = C_IDLE;
        load_data = '0;
        br_offset = '0;
        reset = 1'b0;
        #3;
        chk_state("reset_init", r);
        @(negedge clk);
        reset = 1'b1;

        // Mid-run async reset with a non-empty stack.
        step(C_CALL, 16'h0042, 16'h0, 16'h0042, 1, 0, 0);
        @(negedge clk);
        {stall, pc_load, br_take, call, ret, err_clr} = C_IDLE;
        #2 reset = 1'b0;
        #1 chk_state("reset_mid", r);
        @(negedge clk);
        reset = 1'b1;

        // Sequential wrap and stall (commands ignored while stalled).
        step(C_LOAD,  16'hFFFD, 16'h0, 16'hFFFD, 0, 0, 0);
        step(C_IDLE,  16'h0,    16'h0, 16'hFFFE, 0, 0, 0);
        step(C_IDLE,  16'h0,    16'h0, 16'hFFFF, 0, 0, 0);
        step(C_IDLE,  16'h0,    16'h0, 16'h0000, 0, 0, 0);
        step(C_IDLE,  16'h0,    16'h0, 16'h0001, 0, 0, 0);
        step(C_STALL | C_LOAD | C_CALL, 16'hAAAA, 16'h0, 16'h0001, 0, 0, 0);
        step(C_STALL | C_RET,           16'h0,    16'h0, 16'h0001, 0, 0, 0);

        // Branch, load priority, branch wrap.
        step(C_LOAD,          16'h0010, 16'h0,    16'h0010, 0, 0, 0);
        step(C_BR,            16'h0,    16'hFFF8, 16'h0008, 0, 0, 0);
        step(C_LOAD | C_BR,   16'h1234, 16'h0100, 16'h1234, 0, 0, 0);
        step(C_LOAD,          16'h0002, 16'h0,    16'h0002, 0, 0, 0);
        step(C_BR,            16'h0,    16'hFFFC, 16'hFFFE, 0, 0, 0);

        // Nested call/return.
        step(C_LOAD,          16'h0100, 16'h0, 16'h0100, 0, 0, 0);
        step(C_CALL | C_LOAD, 16'h0200, 16'h0, 16'h0200, 1, 0, 0);
        step(C_CALL | C_BR,   16'h0300, 16'h4, 16'h0300, 2, 0, 0);
        step(C_RET,           16'h0,    16'h0, 16'h0201, 1, 0, 0);
        step(C_RET,           16'h0,    16'h0, 16'h0101, 0, 0, 0);

        // Overflow: fifth push drops 0x0102, then drain and underflow.
        step(C_CALL, 16'hA000, 16'h0, 16'hA000, 1, 0, 0);
        step(C_CALL, 16'hB000, 16'h0, 16'hB000, 2, 0, 0);
        step(C_CALL, 16'hC000, 16'h0, 16'hC000, 3, 0, 0);
        step(C_CALL, 16'hD000, 16'h0, 16'hD000, 4, 0, 0);
        step(C_CALL, 16'hE000, 16'h0, 16'hE000, 4, 1, 0);
        step(C_RET,  16'h0,    16'h0, 16'hD001, 3, 1, 0);
        step(C_RET,  16'h0,    16'h0, 16'hC001, 2, 1, 0);
        step(C_RET,  16'h0,    16'h0, 16'hB001, 1, 1, 0);
        step(C_RET,  16'h0,    16'h0, 16'hA001, 0, 1, 0);
        step(C_RET,  16'h0,    16'h0, 16'hA002, 0, 1, 1);

        // Error clear, simultaneous call+ret, clear vs. new error, stalled clear.
        step(C_CLR,           16'h0,    16'h0, 16'hA003, 0, 0, 0);
        step(C_CALL,          16'h5000, 16'h0, 16'h5000, 1, 0, 0);
        step(C_CALL,          16'h6000, 16'h0, 16'h6000, 2, 0, 0);
        step(C_CALL | C_RET,  16'h7777, 16'h0, 16'h5001, 1, 0, 0);
        step(C_RET,           16'h0,    16'h0, 16'hA004, 0, 0, 0);
        step(C_RET | C_CLR,   16'h0,    16'h0, 16'hA005, 0, 0, 1);
        step(C_STALL | C_CLR, 16'h0,    16'h0, 16'hA005, 0, 0, 1);
        step(C_IDLE,          16'h0,    16'h0, 16'hA006, 0, 0, 1);

        @(negedge clk);
        {stall, pc_load, br_take, call, ret, err_clr} = C_IDLE;
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
